// File: rtl/net_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : net_frame_scheduler
// Brief    : Ethernet link sequencer for the two-player kart game. It sends
//            one local-state packet every FRAMES_PER_TX frames, starting at
//            the first vertical-blank line. It holds the received opponent
//            state and reports link health. Everything runs on eth_refclk.
// Options  : SEQ_FILTER_EN - when defined, a received packet is accepted only
//            if its sequence number is ahead of the last accepted one
//            (signed 8-bit difference). The first packet after reset is
//            always accepted.
// Revision : 1.0 - initial release
// ============================================================================
module net_frame_scheduler #(
    parameter int unsigned VBLANK_LINE         = 768,
    parameter int unsigned FRAMES_PER_TX       = 1,
    parameter int unsigned TX_TIMEOUT_CYCLES   = 4096,
    parameter int unsigned LINK_TIMEOUT_FRAMES = 30,
    parameter int unsigned OPP_X_RST           = 320,
    parameter int unsigned OPP_Y_RST           = 320
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic [8:0]  direction,
    input  logic [1:0]  game_stat,
    input  logic        tx_busy_in,
    input  logic        tx_done_in,
    output logic        tx_start_out,
    output logic [32:0] tx_payload_out,
    output logic [7:0]  tx_seq_out,
    input  logic        rx_valid_in,
    input  logic [32:0] rx_payload_in,
    input  logic [7:0]  rx_seq_in,
    output logic [10:0] opponent_x,
    output logic [10:0] opponent_y,
    output logic [8:0]  opponent_dir,
    output logic [1:0]  opponent_stat,
    output logic        link_up,
    output logic [7:0]  tx_err_count,
    output logic [7:0]  drop_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_tmo_w  = $clog2(TX_TIMEOUT_CYCLES + 1);
    localparam int unsigned c_link_w = $clog2(LINK_TIMEOUT_FRAMES + 1);

    localparam logic [9:0]          c_vblank_line = 10'(VBLANK_LINE);
    localparam logic [3:0]          c_div_last    = 4'(FRAMES_PER_TX - 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last    = c_tmo_w'(TX_TIMEOUT_CYCLES - 1);
    localparam logic [c_link_w-1:0] c_link_max    = c_link_w'(LINK_TIMEOUT_FRAMES);
    localparam logic [10:0]         c_opp_x_rst   = 11'(OPP_X_RST);
    localparam logic [10:0]         c_opp_y_rst   = 11'(OPP_Y_RST);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_latch     = 2'd1;
    localparam logic [1:0] c_st_start     = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                r_frame_tick;
    logic [3:0]          r_div;
    logic                r_pending;
    logic [7:0]          r_drop_count;

    logic [1:0]          r_state;
    logic                r_tx_start;
    logic [32:0]         r_tx_payload;
    logic [7:0]          r_tx_seq;
    logic [c_tmo_w-1:0]  r_tx_tmo;
    logic [7:0]          r_tx_err_count;

    logic [10:0]         r_opp_x;
    logic [10:0]         r_opp_y;
    logic [8:0]          r_opp_dir;
    logic [1:0]          r_opp_stat;

    logic [c_link_w-1:0] r_link_timer;
    logic                r_link_up;

    logic                w_tick_cond;
    logic                w_div_wrap;
    logic                w_rx_accept;
    logic [c_link_w-1:0] w_link_timer_nxt;

    // ------------------------------------------------------------------------
    // Frame tick: first pixel of the first blank line, registered
    // ------------------------------------------------------------------------
    assign w_tick_cond = (vcount_in == c_vblank_line) && (hcount_in == 11'd0);

    // One-cycle tick, one cycle after the first pixel of the blank line
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick_cond;
        end
    end

    // ------------------------------------------------------------------------
    // Frame divider and send request
    // ------------------------------------------------------------------------
    assign w_div_wrap = r_frame_tick && (r_div == c_div_last);

    // Count ticks modulo FRAMES_PER_TX
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div <= 4'd0;
        end else if (r_frame_tick) begin
            if (r_div == c_div_last) begin
                r_div <= 4'd0;
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    // A wrap raises the request. It is counted as a drop if one is still outstanding.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pending    <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            // LATCH consumes the request. A wrap in that same cycle was
            // already counted as a drop below, so nothing is re-armed.
            if (r_state == c_st_latch) begin
                r_pending <= 1'b0;
            end else if (w_div_wrap) begin
                r_pending <= 1'b1;
            end
            if (w_div_wrap && r_pending && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transmit sequencer
    // ------------------------------------------------------------------------
    // IDLE -> LATCH -> START -> WAIT_DONE, then back to IDLE on done or timeout
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= c_st_idle;
            r_tx_start     <= 1'b0;
            r_tx_payload   <= 33'd0;
            r_tx_seq       <= 8'd0;
            r_tx_tmo       <= '0;
            r_tx_err_count <= 8'd0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (r_pending && !tx_busy_in) begin
                        r_state <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    r_tx_payload <= {game_stat, direction, player_y, player_x};
                    // Registered so the pulse lines up with the START cycle
                    r_tx_start   <= 1'b1;
                    r_state      <= c_st_start;
                end
                c_st_start: begin
                    r_tx_tmo <= '0;
                    r_state  <= c_st_wait_done;
                end
                c_st_wait_done: begin
                    if (tx_done_in) begin
                        r_tx_seq <= r_tx_seq + 8'd1;
                        r_state  <= c_st_idle;
                    end else if (r_tx_tmo == c_tmo_last) begin
                        // Abort: keep the sequence number so the next packet reuses it
                        if (r_tx_err_count != 8'hFF) begin
                            r_tx_err_count <= r_tx_err_count + 8'd1;
                        end
                        r_state <= c_st_idle;
                    end else begin
                        r_tx_tmo <= r_tx_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Receive acceptance
    // ------------------------------------------------------------------------
`ifdef SEQ_FILTER_EN
    logic [7:0] r_last_rx_seq;
    logic       r_rx_seen;
    logic [7:0] w_seq_delta;

    // Modulo-256 distance. The top bit set means "behind", zero means a repeat.
    assign w_seq_delta = rx_seq_in - r_last_rx_seq;
    assign w_rx_accept = rx_valid_in &&
                         (!r_rx_seen || (!w_seq_delta[7] && (w_seq_delta != 8'd0)));

    // Remember the last accepted sequence number
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last_rx_seq <= 8'd0;
            r_rx_seen     <= 1'b0;
        end else if (w_rx_accept) begin
            r_last_rx_seq <= rx_seq_in;
            r_rx_seen     <= 1'b1;
        end
    end
`else
    logic w_unused_rx_seq;

    assign w_rx_accept     = rx_valid_in;
    assign w_unused_rx_seq = ^rx_seq_in;
`endif

    // Capture opponent state on every accepted packet. Hold it otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_opp_x    <= c_opp_x_rst;
            r_opp_y    <= c_opp_y_rst;
            r_opp_dir  <= 9'd0;
            r_opp_stat <= 2'd0;
        end else if (w_rx_accept) begin
            r_opp_x    <= rx_payload_in[10:0];
            r_opp_y    <= rx_payload_in[21:11];
            r_opp_dir  <= rx_payload_in[30:22];
            r_opp_stat <= rx_payload_in[32:31];
        end
    end

    // ------------------------------------------------------------------------
    // Link health
    // ------------------------------------------------------------------------
    // Next timer value. An accept outranks a coincident frame tick.
    always_comb begin
        w_link_timer_nxt = r_link_timer;
        if (w_rx_accept) begin
            w_link_timer_nxt = '0;
        end else if (r_frame_tick && (r_link_timer != c_link_max)) begin
            w_link_timer_nxt = r_link_timer + 1'b1;
        end
    end

    // Timer and link_up move together, so link_up rises alongside the opponent update
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_link_timer <= c_link_max;
            r_link_up    <= 1'b0;
        end else begin
            r_link_timer <= w_link_timer_nxt;
            r_link_up    <= (w_link_timer_nxt < c_link_max);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_start_out   = r_tx_start;
    assign tx_payload_out = r_tx_payload;
    assign tx_seq_out     = r_tx_seq;
    assign tx_err_count   = r_tx_err_count;
    assign drop_count     = r_drop_count;
    assign opponent_x     = r_opp_x;
    assign opponent_y     = r_opp_y;
    assign opponent_dir   = r_opp_dir;
    assign opponent_stat  = r_opp_stat;
    assign link_up        = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_net_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_net_frame_scheduler
// Brief    : Scoreboard bench for net_frame_scheduler. Stimulus tasks push the
//            expected transmit/receive responses. Monitors pop and compare them
//            when the DUT presents them. A second instance with FRAMES_PER_TX=2
//            covers the frame divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_net_frame_scheduler;

`ifdef SEQ_FILTER_EN
    localparam bit c_filt = 1'b1;
`else
    localparam bit c_filt = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rst2_n;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [8:0]  direction;
    logic [1:0]  game_stat;
    logic        tx_busy_in;
    logic        tx_done_in;
    logic        tx_done2;
    logic        rx_valid_in;
    logic [32:0] rx_payload_in;
    logic [7:0]  rx_seq_in;

    logic        tx_start_out;
    logic [32:0] tx_payload_out;
    logic [7:0]  tx_seq_out;
    logic [10:0] opponent_x;
    logic [10:0] opponent_y;
    logic [8:0]  opponent_dir;
    logic [1:0]  opponent_stat;
    logic        link_up;
    logic [7:0]  tx_err_count;
    logic [7:0]  drop_count;

    logic        tx_start2;
    logic [32:0] tx_payload2;
    logic [7:0]  tx_seq2;
    logic [10:0] opp_x2;
    logic [10:0] opp_y2;
    logic [8:0]  opp_dir2;
    logic [1:0]  opp_stat2;
    logic        link_up2;
    logic [7:0]  tx_err2;
    logic [7:0]  drop2;

    always #5 clk_in = ~clk_in;

    net_frame_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .player_x(player_x), .player_y(player_y),
        .direction(direction), .game_stat(game_stat),
        .tx_busy_in(tx_busy_in), .tx_done_in(tx_done_in),
        .tx_start_out(tx_start_out), .tx_payload_out(tx_payload_out),
        .tx_seq_out(tx_seq_out),
        .rx_valid_in(rx_valid_in), .rx_payload_in(rx_payload_in),
        .rx_seq_in(rx_seq_in),
        .opponent_x(opponent_x), .opponent_y(opponent_y),
        .opponent_dir(opponent_dir), .opponent_stat(opponent_stat),
        .link_up(link_up), .tx_err_count(tx_err_count), .drop_count(drop_count)
    );

    net_frame_scheduler #(.FRAMES_PER_TX(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst2_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .player_x(player_x), .player_y(player_y),
        .direction(direction), .game_stat(game_stat),
        .tx_busy_in(tx_busy_in), .tx_done_in(tx_done2),
        .tx_start_out(tx_start2), .tx_payload_out(tx_payload2),
        .tx_seq_out(tx_seq2),
        .rx_valid_in(rx_valid_in), .rx_payload_in(rx_payload_in),
        .rx_seq_in(rx_seq_in),
        .opponent_x(opp_x2), .opponent_y(opp_y2),
        .opponent_dir(opp_dir2), .opponent_stat(opp_stat2),
        .link_up(link_up2), .tx_err_count(tx_err2), .drop_count(drop2)
    );

    typedef struct {
        logic [32:0] payload;
        logic [7:0]  seq;
        longint      cyc;
    } tx_exp_t;

    typedef struct {
        longint      cyc;
        logic [10:0] x;
        logic [10:0] y;
        logic [8:0]  dir;
        logic [1:0]  stat;
        logic        link;
    } rx_exp_t;

    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     auto_done;
    logic [7:0] exp_seq;
    int     tick_idx;
    int     n2;
    int     st2[4];

    logic [10:0] m_x;
    logic [10:0] m_y;
    logic [8:0]  m_dir;
    logic [1:0]  m_stat;
    logic        m_link;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [32:0] pack();
        return {game_stat, direction, player_y, player_x};
    endfunction

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk_in);
    endtask

    // One frame tick; optionally expect a send 3 cycles after the tick
    task automatic frame_tick(input bit expect_tx, input logic [32:0] pl, output longint k_out);
        tx_exp_t e;
        @(negedge clk_in);
        k_out = cyc;
        vcount_in = 10'd768;
        hcount_in = 11'd0;
        tick_idx++;
        if (expect_tx) begin
            e.payload = pl;
            e.seq     = exp_seq;
            e.cyc     = cyc + 4;
            tx_q.push_back(e);
            if (auto_done) exp_seq = exp_seq + 8'd1;
        end
        @(negedge clk_in);
        vcount_in = 10'd0;
        hcount_in = 11'd5;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic rx_pkt(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                          input logic [1:0] s, input logic [7:0] seq, input bit accept);
        rx_exp_t e;
        @(negedge clk_in);
        rx_valid_in   = 1'b1;
        rx_payload_in = {s, d, y, x};
        rx_seq_in     = seq;
        if (accept) begin
            m_x = x; m_y = y; m_dir = d; m_stat = s; m_link = 1'b1;
        end
        e.cyc = cyc + 1;
        e.x = m_x; e.y = m_y; e.dir = m_dir; e.stat = m_stat; e.link = m_link;
        rx_q.push_back(e);
        @(negedge clk_in);
        rx_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    // Transmit scoreboard monitor and receive monitor
    initial begin
        tx_exp_t te;
        rx_exp_t re;
        forever begin
            @(negedge clk_in);
            if (tx_start_out === 1'b1) begin
                if (tx_q.size() == 0) begin
                    check("tx_start_unexpected", 64'(tx_start_out), 64'd0);
                end else begin
                    te = tx_q.pop_front();
                    check("tx_payload", 64'(tx_payload_out), 64'(te.payload));
                    check("tx_seq", 64'(tx_seq_out), 64'(te.seq));
                    if (te.cyc >= 0) check("tx_start_cycle", 64'(cyc), 64'(te.cyc));
                end
            end
            if (rx_q.size() != 0 && rx_q[0].cyc == cyc) begin
                re = rx_q.pop_front();
                check("opp_x", 64'(opponent_x), 64'(re.x));
                check("opp_y", 64'(opponent_y), 64'(re.y));
                check("opp_dir", 64'(opponent_dir), 64'(re.dir));
                check("opp_stat", 64'(opponent_stat), 64'(re.stat));
                check("rx_link_up", 64'(link_up), 64'(re.link));
            end
        end
    end

    // Start-pulse logger for the divide-by-2 instance
    initial begin
        n2 = 0;
        forever begin
            @(negedge clk_in);
            if (tx_start2 === 1'b1) begin
                if (n2 < 4) st2[n2] = tick_idx;
                n2++;
            end
        end
    end

    // Transmitter model for the main instance: done 4 cycles after start
    initial begin
        tx_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            tx_done_in = 1'b0;
            if (tx_start_out === 1'b1 && auto_done) begin
                repeat (4) @(negedge clk_in);
                tx_done_in = 1'b1;
            end
        end
    end

    // Transmitter model for the divide-by-2 instance
    initial begin
        tx_done2 = 1'b0;
        forever begin
            @(negedge clk_in);
            tx_done2 = 1'b0;
            if (tx_start2 === 1'b1) begin
                repeat (4) @(negedge clk_in);
                tx_done2 = 1'b1;
            end
        end
    end

    initial begin
        longint k;
        tx_exp_t e;

        rst_in = 1'b0; rst2_n = 1'b0;
        hcount_in = 11'd5; vcount_in = 10'd0;
        player_x = 11'd0; player_y = 11'd0; direction = 9'd0; game_stat = 2'd0;
        tx_busy_in = 1'b0; rx_valid_in = 1'b0; rx_payload_in = 33'd0; rx_seq_in = 8'd0;
        auto_done = 1'b1; exp_seq = 8'd0; tick_idx = 0;
        m_x = 11'd320; m_y = 11'd320; m_dir = 9'd0; m_stat = 2'd0; m_link = 1'b0;

        repeat (3) @(negedge clk_in);
        check("rst_tx_start", 64'(tx_start_out), 64'd0);
        check("rst_tx_payload", 64'(tx_payload_out), 64'd0);
        check("rst_tx_seq", 64'(tx_seq_out), 64'd0);
        check("rst_opp_x", 64'(opponent_x), 64'd320);
        check("rst_opp_y", 64'(opponent_y), 64'd320);
        check("rst_opp_dir", 64'(opponent_dir), 64'd0);
        check("rst_opp_stat", 64'(opponent_stat), 64'd0);
        check("rst_link_up", 64'(link_up), 64'd0);
        check("rst_tx_err", 64'(tx_err_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Basic send: latency, payload packing, sequence advance
        player_x = 11'd191; player_y = 11'd191; direction = 9'd270; game_stat = 2'd1;
        frame_tick(1'b1, 33'h0C385F8BF, k);
        check("seq_after_done", 64'(tx_seq_out), 64'd1);

        // Divider: the FRAMES_PER_TX=2 instance sends on ticks 2 and 4
        @(negedge clk_in);
        rst2_n = 1'b1;
        tick_idx = 0;
        player_x = 11'd500; player_y = 11'd20; direction = 9'd45; game_stat = 2'd2;
        repeat (4) frame_tick(1'b1, pack(), k);
        check("div2_start_count", 64'(n2), 64'd2);
        check("div2_first_tick", 64'(st2[0]), 64'd2);
        check("div2_second_tick", 64'(st2[1]), 64'd4);

        // Timeout: no done -> abort after 4096 wait cycles, seq unchanged
        auto_done = 1'b0;
        player_x = 11'd7; player_y = 11'd1023; direction = 9'd359; game_stat = 2'd3;
        frame_tick(1'b1, pack(), k);
        wait_until(k + 4096);
        check("tmo_err_before", 64'(tx_err_count), 64'd0);
        wait_until(k + 4106);
        check("tmo_err_after", 64'(tx_err_count), 64'd1);
        check("tmo_seq_kept", 64'(tx_seq_out), 64'(exp_seq));
        auto_done = 1'b1;
        frame_tick(1'b1, pack(), k);
        check("seq_after_retry", 64'(tx_seq_out), 64'(exp_seq));

        // Busy across three ticks: one pending, two drops, one send after release
        tx_busy_in = 1'b1;
        repeat (3) frame_tick(1'b0, pack(), k);
        check("busy_drop_count", 64'(drop_count), 64'd2);
        @(negedge clk_in);
        tx_busy_in = 1'b0;
        e.payload = pack();
        e.seq     = exp_seq;
        e.cyc     = cyc + 2;
        tx_q.push_back(e);
        exp_seq = exp_seq + 8'd1;
        repeat (14) @(negedge clk_in);
        check("busy_drop_hold", 64'(drop_count), 64'd2);
        check("busy_seq", 64'(tx_seq_out), 64'(exp_seq));

        // Receive and link supervision
        check("link_down_before_rx", 64'(link_up), 64'd0);
        rx_pkt(11'd400, 11'd250, 9'd90, 2'd1, 8'd1, 1'b1);
        repeat (29) frame_tick(1'b1, pack(), k);
        check("link_up_29_ticks", 64'(link_up), 64'd1);
        frame_tick(1'b1, pack(), k);
        check("link_down_30_ticks", 64'(link_up), 64'd0);
        check("hold_opp_x", 64'(opponent_x), 64'd400);
        check("hold_opp_y", 64'(opponent_y), 64'd250);
        check("hold_opp_dir", 64'(opponent_dir), 64'd90);
        m_link = 1'b0;

        // Sequence handling: 5, 5, 4, 6
        rx_pkt(11'd100, 11'd110, 9'd10, 2'd2, 8'd5, 1'b1);
        rx_pkt(11'd101, 11'd111, 9'd11, 2'd3, 8'd5, !c_filt);
        rx_pkt(11'd102, 11'd112, 9'd12, 2'd0, 8'd4, !c_filt);
        rx_pkt(11'd103, 11'd113, 9'd13, 2'd1, 8'd6, 1'b1);

        repeat (4) @(negedge clk_in);
        check("tx_queue_drained", 64'(tx_q.size()), 64'd0);
        check("rx_queue_drained", 64'(rx_q.size()), 64'd0);
        check("final_tx_err", 64'(tx_err_count), 64'd1);
        check("final_drop", 64'(drop_count), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
